// File: rtl/conv2d_read_dma.sv
// Read DMA for a conv2d engine: splits one (address, length) request into
// MAX_BURST-sized memory bursts and forwards the returned beats to compute.
module conv2d_read_dma #(
   parameter int AWIDTH    = 32,
   parameter int DWIDTH    = 32,
   parameter int MAX_BURST = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AWIDTH-1:0] req_read_addr,
   input  logic [31:0]       req_read_len,
   input  logic              req_read_addr_valid,
   output logic              req_read_addr_ready,
   output logic [DWIDTH-1:0] rdata,
   output logic              rdata_valid,
   input  logic              rdata_ready,
   output logic [AWIDTH-1:0] m_araddr,
   output logic [7:0]        m_arlen,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  logic [DWIDTH-1:0] m_rdata,
   input  logic              m_rvalid,
   input  logic              m_rlast,
   output logic              m_rready,
   output logic              idle,
   output logic              err,
   output logic [1:0]        dbg_state
);
   localparam int BYTES = DWIDTH / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t            state;
   logic [AWIDTH-1:0] cur_addr;
   logic [31:0]       remaining;
   logic [8:0]        burst_cnt;
   logic [8:0]        beats;

   // remaining <= MAX_BURST <= 256 in the narrow branch, so 9 bits hold it exactly.
   always_comb begin
      beats = 9'(MAX_BURST);
      if (remaining < 32'(MAX_BURST)) beats = remaining[8:0];
   end

   // Every channel transfers on the cycle where valid && ready are both high at
   // the rising edge; valid never waits on ready, and address/len stay stable
   // while valid is held.
   assign req_read_addr_ready = (state == IDLE);
   assign idle                = (state == IDLE);
   assign m_arvalid           = (state == ADDR);
   assign m_araddr            = cur_addr;
   assign m_arlen             = 8'(beats - 9'd1);
   assign rdata               = m_rdata;
   assign rdata_valid         = (state == DATA) && m_rvalid;
   assign m_rready            = (state == DATA) && rdata_ready;
   assign dbg_state           = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cur_addr  <= '0;
         remaining <= '0;
         burst_cnt <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_read_addr_valid && (req_read_len != 32'd0)) begin
                  cur_addr  <= req_read_addr;
                  remaining <= req_read_len;
                  state     <= ADDR;
               end
            end
            ADDR: begin
               // Advance the address at AR acceptance; it is only visible again in ADDR.
               if (m_arready) begin
                  burst_cnt <= beats;
                  cur_addr  <= cur_addr + AWIDTH'(beats) * AWIDTH'(BYTES);
                  state     <= DATA;
               end
            end
            DATA: begin
               if (m_rvalid && rdata_ready) begin
                  burst_cnt <= burst_cnt - 9'd1;
                  remaining <= remaining - 32'd1;
                  if (m_rlast != (burst_cnt == 9'd1)) err <= 1'b1;
                  if (burst_cnt == 9'd1) state <= (remaining == 32'd1) ? IDLE : ADDR;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv2d_read_dma.sv
// Self-checking bench for conv2d_read_dma: memory responder, random backpressure,
// beat and AR scoreboards fed by the request driver.
module tb_conv2d_read_dma;
   localparam int MB = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] req_read_addr;
   logic [31:0] req_read_len;
   logic        req_read_addr_valid;
   logic        req_read_addr_ready;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        rdata_ready;
   logic [31:0] m_araddr;
   logic [7:0]  m_arlen;
   logic        m_arvalid;
   logic        m_arready;
   logic [31:0] m_rdata;
   logic        m_rvalid;
   logic        m_rlast;
   logic        m_rready;
   logic        idle;
   logic        err;
   logic [1:0]  dbg_state;

   logic [31:0] exp_q[$];
   logic [39:0] exp_ar_q[$];
   int          checks = 0;
   int          passed = 0;
   int          n_beats = 0;
   bit          rand_rdy = 0;
   bit          rand_mem = 0;
   bit          hold_rdy = 0;
   bit          mirror_chk = 0;
   int          inject_idx = -1;

   conv2d_read_dma #(.AWIDTH(32), .DWIDTH(32), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .req_read_addr(req_read_addr), .req_read_len(req_read_len),
      .req_read_addr_valid(req_read_addr_valid), .req_read_addr_ready(req_read_addr_ready),
      .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
      .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
      .idle(idle), .err(err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return (a * 32'd7) ^ 32'hC0DE_0000;
   endfunction

   // Memory responder: one burst at a time, data derived from the beat address.
   logic [31:0] b_addr;
   int          b_beats, b_idx;
   bit          b_active;
   initial begin
      bit          ar_f, r_f, rst_s;
      logic [31:0] a_s;
      logic [7:0]  l_s;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
      b_active = 0; b_idx = 0; b_beats = 0; b_addr = '0;
      forever begin
         @(negedge clk);
         ar_f = m_arvalid && m_arready;
         r_f  = m_rvalid && m_rready;
         rst_s = rst;
         a_s = m_araddr;
         l_s = m_arlen;
         @(posedge clk); #1;
         if (rst_s) begin
            b_active = 0; b_idx = 0;
         end else begin
            if (r_f && b_active) begin
               b_idx++;
               if (b_idx == b_beats) b_active = 0;
            end
            if (ar_f) begin
               b_active = 1; b_addr = a_s; b_beats = int'(l_s) + 1; b_idx = 0;
            end
         end
         m_arready = rand_mem ? 1'($urandom_range(0, 1)) : 1'b1;
         m_rvalid  = b_active && (rand_mem ? ($urandom_range(0, 1) == 1) : 1'b1);
         m_rdata   = pat(b_addr + 32'(b_idx) * 32'd4);
         m_rlast   = b_active && ((b_idx == b_beats - 1) || (b_idx == inject_idx));
      end
   end

   initial begin
      rdata_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         rdata_ready = hold_rdy ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   always @(negedge clk) begin : monitor
      logic [31:0] e;
      logic [39:0] ea;
      if (!rst && rdata_valid && rdata_ready) begin
         n_beats++;
         checks++;
         if (exp_q.size() == 0) $display("FAIL beat: got %h, expected no beat", rdata);
         else begin
            e = exp_q.pop_front();
            if (rdata !== e) $display("FAIL beat: got %h expected %h", rdata, e);
            else passed++;
         end
      end
      if (!rst && m_arvalid && m_arready) begin
         checks++;
         if (exp_ar_q.size() == 0) $display("FAIL ar: got %h/%0d, expected no AR", m_araddr, m_arlen);
         else begin
            ea = exp_ar_q.pop_front();
            if ({m_araddr, m_arlen} !== ea)
               $display("FAIL ar: got %h/%0d expected %h/%0d", m_araddr, m_arlen, ea[39:8], ea[7:0]);
            else passed++;
         end
      end
      if (mirror_chk && !rst) begin
         checks++;
         if (m_rready !== ((dbg_state == 2'd2) ? rdata_ready : 1'b0))
            $display("FAIL m_rready mirror: got %b rdata_ready %b state %0d", m_rready, rdata_ready, dbg_state);
         else passed++;
      end
   end

   task automatic issue(input logic [31:0] addr, input logic [31:0] len);
      logic [31:0] a;
      int rem, b;
      a = addr;
      rem = int'(len);
      for (int i = 0; i < int'(len); i++) exp_q.push_back(pat(addr + 32'(i) * 32'd4));
      while (rem > 0) begin
         b = (rem > MB) ? MB : rem;
         exp_ar_q.push_back({a, 8'(b - 1)});
         a = a + 32'(b) * 32'd4;
         rem -= b;
      end
      checks++;
      if (req_read_addr_ready !== 1'b1) $display("FAIL req ready: got %b expected 1", req_read_addr_ready);
      else passed++;
      req_read_addr = addr; req_read_len = len; req_read_addr_valid = 1'b1;
      @(posedge clk); #2;
      req_read_addr_valid = 1'b0;
      if (len != 0) begin
         checks++;
         if (m_arvalid !== 1'b1 || m_araddr !== addr)
            $display("FAIL ar latency: got arvalid %b addr %h expected 1 %h", m_arvalid, m_araddr, addr);
         else passed++;
      end
   endtask

   task automatic wait_done(input string name);
      int cyc = 0;
      while ((exp_q.size() != 0 || exp_ar_q.size() != 0) && cyc < 5000) begin
         @(posedge clk); #2;
         cyc++;
      end
      checks++;
      if (cyc >= 5000) begin
         $display("FAIL %s timeout: %0d beats %0d ARs still expected", name, exp_q.size(), exp_ar_q.size());
         exp_q.delete(); exp_ar_q.delete();
      end else if (idle !== 1'b1) $display("FAIL %s idle after last beat: got %b expected 1", name, idle);
      else passed++;
   endtask

   task automatic test_reset;
      rst = 1'b1; req_read_addr_valid = 1'b0; req_read_addr = '0; req_read_len = '0;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if ({idle, req_read_addr_ready, m_arvalid, rdata_valid, m_rready, err} !== 6'b110000)
         $display("FAIL reset outputs: got %b expected 110000",
                  {idle, req_read_addr_ready, m_arvalid, rdata_valid, m_rready, err});
      else passed++;
      rst = 1'b0;
   endtask

   task automatic test_single;
      int start = n_beats;
      issue(32'h1000, 32'd9);
      wait_done("single");
      checks++;
      if (n_beats - start != 9 || err !== 1'b0)
         $display("FAIL single: got %0d beats err %b expected 9 beats err 0", n_beats - start, err);
      else passed++;
   endtask

   task automatic test_split;
      int start = n_beats;
      issue(32'h0, 32'd600);
      wait_done("split");
      checks++;
      if (n_beats - start != 600 || err !== 1'b0)
         $display("FAIL split: got %0d beats err %b expected 600 beats err 0", n_beats - start, err);
      else passed++;
   endtask

   task automatic test_zero_len;
      issue(32'h5000, 32'd0);
      repeat (10) begin
         @(negedge clk);
         checks++;
         if ({m_arvalid, idle, req_read_addr_ready, rdata_valid} !== 4'b0110)
            $display("FAIL zero len: got arvalid/idle/ready/rvalid %b expected 0110",
                     {m_arvalid, idle, req_read_addr_ready, rdata_valid});
         else passed++;
      end
      @(posedge clk); #2;
   endtask

   task automatic test_backpressure;
      int start = n_beats;
      rand_rdy = 1; rand_mem = 1; mirror_chk = 1;
      issue(32'h3000, 32'd20);
      wait_done("backpressure");
      mirror_chk = 0; rand_rdy = 0; rand_mem = 0;
      checks++;
      if (n_beats - start != 20) $display("FAIL backpressure count: got %0d expected 20", n_beats - start);
      else passed++;
   endtask

   task automatic test_rlast_err;
      int cyc = 0;
      bit chk0 = 0;
      inject_idx = 1;
      issue(32'h4000, 32'd4);
      while (exp_q.size() > 2 && cyc < 200) begin
         @(posedge clk); #2;
         cyc++;
         if (exp_q.size() == 3 && !chk0) begin
            chk0 = 1;
            checks++;
            if (err !== 1'b0) $display("FAIL err before bad rlast: got %b expected 0", err);
            else passed++;
         end
      end
      checks++;
      if (err !== 1'b1) $display("FAIL err after bad rlast: got %b expected 1", err);
      else passed++;
      wait_done("rlast_err");
      repeat (5) @(posedge clk);
      #2;
      checks++;
      if (err !== 1'b1 || idle !== 1'b1) $display("FAIL err sticky: got err %b idle %b expected 1 1", err, idle);
      else passed++;
      inject_idx = -1;
   endtask

   task automatic test_reset_mid;
      int cyc = 0;
      issue(32'h6000, 32'd9);
      while (exp_q.size() > 6 && cyc < 200) begin
         @(posedge clk); #2;
         cyc++;
      end
      hold_rdy = 1; rdata_ready = 1'b0; rst = 1'b1;
      @(posedge clk); #2;
      exp_q.delete(); exp_ar_q.delete();
      checks++;
      if ({idle, req_read_addr_ready, m_arvalid, rdata_valid, m_rready, err} !== 6'b110000)
         $display("FAIL mid reset outputs: got %b expected 110000",
                  {idle, req_read_addr_ready, m_arvalid, rdata_valid, m_rready, err});
      else passed++;
      rst = 1'b0; hold_rdy = 0;
      issue(32'h2000, 32'd2);
      wait_done("after_reset");
      checks++;
      if (err !== 1'b0) $display("FAIL after reset err: got %b expected 0", err);
      else passed++;
   endtask

   task automatic test_back_to_back;
      issue(32'h7000, 32'd3);
      wait_done("b2b_first");
      issue(32'h7100, 32'd5);
      wait_done("b2b_second");
      rand_rdy = 1; rand_mem = 1;
      for (int k = 0; k < 3; k++) begin
         issue(32'h10000 + 32'($urandom_range(0, 255)) * 32'd4, 32'($urandom_range(1, 300)));
         wait_done("random");
      end
      rand_rdy = 0; rand_mem = 0;
      checks++;
      if (err !== 1'b0) $display("FAIL back to back err: got %b expected 0", err);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_split();
      test_zero_len();
      test_backpressure();
      test_rlast_err();
      test_reset();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
